// File: rtl/inst_mem_loader_if.sv
// Byte-stream and instruction-memory write bundle for inst_mem_loader.
// master = boot source / testbench side, slave = the loader itself.
interface inst_mem_loader_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              i_start;
    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              o_rx_ready;
    logic              o_we;
    logic [ADDR_W-1:0] o_waddr;
    logic [31:0]       o_wdata;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic              o_cpu_rst_n;

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_rx_ready, o_we, o_waddr, o_wdata, o_busy, o_done, o_err, o_cpu_rst_n
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_rx_ready, o_we, o_waddr, o_wdata, o_busy, o_done, o_err, o_cpu_rst_n
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot loader: header (16-bit word count) + little-endian words -> instruction memory.
// Optional trailing 8-bit checksum of data bytes when INST_LOADER_CHKSUM_EN is defined.
module inst_mem_loader #(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
    parameter int unsigned          MAX_WORDS = 1024
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    inst_mem_loader_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_DONE
`ifdef INST_LOADER_CHKSUM_EN
        , S_CHK
`endif
    } state_e;

`ifdef INST_LOADER_CHKSUM_EN
    localparam state_e S_TAIL = S_CHK;
`else
    localparam state_e S_TAIL = S_DONE;
`endif

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic              rdy_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic              cpu_rst_n_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [15:0]       cnt_q;
    logic [15:0]       idx_q;
    logic [1:0]        lane_q;
    logic [23:0]       sh_q;
`ifdef INST_LOADER_CHKSUM_EN
    logic [7:0]        sum_q;
`endif

    logic        consume;
    logic [15:0] count_full;
    logic        last_word;
    logic        rdy_d;

    assign consume    = bus.i_rx_valid && rdy_q;
    assign count_full = {bus.i_rx_data, cnt_q[7:0]};
    assign last_word  = ((17'(idx_q) + 17'd1) == 17'(cnt_q));

    // Next state and sticky error
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.i_start) begin
                    state_d = S_HDR0;
                    err_d   = 1'b0;
                end
            end
            S_HDR0: if (consume) state_d = S_HDR1;
            S_HDR1: begin
                if (consume) begin
                    if (count_full == 16'd0) begin
                        state_d = S_TAIL;
                    end else if (32'(count_full) > MAX_WORDS) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA:  if (consume && lane_q == 2'd3) state_d = S_WRITE;
            S_WRITE: state_d = last_word ? S_TAIL : S_DATA;
`ifdef INST_LOADER_CHKSUM_EN
            S_CHK: begin
                if (consume) begin
                    if (bus.i_rx_data != sum_q) err_d = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdy_d = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
`ifdef INST_LOADER_CHKSUM_EN
        rdy_d = rdy_d || (state_d == S_CHK);
`endif
    end

    // State, registered outputs and word assembly
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            err_q       <= 1'b0;
            rdy_q       <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            waddr_q     <= BASE_ADDR;
            wdata_q     <= 32'd0;
            cnt_q       <= 16'd0;
            idx_q       <= 16'd0;
            lane_q      <= 2'd0;
            sh_q        <= 24'd0;
`ifdef INST_LOADER_CHKSUM_EN
            sum_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            rdy_q       <= rdy_d;
            we_q        <= (state_d == S_WRITE);
            busy_q      <= !((state_d == S_IDLE) || (state_d == S_DONE));
            done_q      <= (state_d == S_DONE);
            cpu_rst_n_q <= (state_d == S_DONE) && !err_d;

            case (state_q)
                S_HDR0: if (consume) cnt_q[7:0] <= bus.i_rx_data;
                S_HDR1: begin
                    if (consume) begin
                        cnt_q[15:8] <= bus.i_rx_data;
                        idx_q       <= 16'd0;
                        lane_q      <= 2'd0;
`ifdef INST_LOADER_CHKSUM_EN
                        sum_q       <= 8'd0;
`endif
                    end
                end
                S_DATA: begin
                    if (consume) begin
                        lane_q <= lane_q + 2'd1;
`ifdef INST_LOADER_CHKSUM_EN
                        sum_q  <= sum_q + bus.i_rx_data;
`endif
                        case (lane_q)
                            2'd0:    sh_q[7:0]   <= bus.i_rx_data;
                            2'd1:    sh_q[15:8]  <= bus.i_rx_data;
                            2'd2:    sh_q[23:16] <= bus.i_rx_data;
                            default: begin
                                // Lane 3 goes straight into the write word
                                wdata_q <= {bus.i_rx_data, sh_q};
                                waddr_q <= BASE_ADDR + ADDR_W'({idx_q, 2'b00});
                            end
                        endcase
                    end
                end
                S_WRITE: idx_q <= idx_q + 16'd1;
                default: ;
            endcase
        end
    end

    assign bus.o_rx_ready  = rdy_q;
    assign bus.o_we        = we_q;
    assign bus.o_waddr     = waddr_q;
    assign bus.o_wdata     = wdata_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;
    assign bus.o_cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader; honours INST_LOADER_CHKSUM_EN like the RTL.
module tb_inst_mem_loader;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MAX_WORDS = 1024;

    typedef logic [7:0] byte_q_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    inst_mem_loader #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (32'h0),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] got_a[$];
    logic [31:0] got_d[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic        exp_err;
    int          we_b2b  = 0;
    logic        we_prev = 1'b0;

    // Write-port monitor
    always @(negedge clk) begin
        if (bus.o_we) begin
            got_a.push_back(bus.o_waddr);
            got_d.push_back(bus.o_wdata);
            if (we_prev) we_b2b++;
        end
        we_prev = bus.o_we;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decode the whole stream into expected writes and error flag
    task automatic model(input byte_q_t s);
        int          cnt;
        logic [31:0] w;
        int          sum;
        exp_a.delete();
        exp_d.delete();
        exp_err = 1'b0;
        sum     = 0;
        cnt     = int'(s[0]) + 256 * int'(s[1]);
        if (cnt > int'(MAX_WORDS)) begin
            exp_err = 1'b1;
            return;
        end
        for (int k = 0; k < cnt; k++) begin
            w = 32'(s[2+4*k]) | (32'(s[3+4*k]) << 8) | (32'(s[4+4*k]) << 16) | (32'(s[5+4*k]) << 24);
            exp_a.push_back(32'(4 * k));
            exp_d.push_back(w);
            for (int b = 0; b < 4; b++) sum += int'(s[2+4*k+b]);
        end
`ifdef INST_LOADER_CHKSUM_EN
        if (int'(s[2+4*cnt]) != (sum % 256)) exp_err = 1'b1;
`endif
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    // mode 0: valid every cycle, 1: toggling, 2: random
    task automatic feed(input byte_q_t s, input int mode, input int start_at);
        int   i = 0;
        int   cyc = 0;
        logic v;
        logic started = 1'b0;
        while (i < s.size() && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            bus.i_start = 1'b0;
            if (i == start_at && !started) begin
                bus.i_start = 1'b1;
                started     = 1'b1;
            end
            bus.i_rx_valid = v;
            bus.i_rx_data  = v ? s[i] : 8'($urandom);
            if (v && bus.o_rx_ready) i++;
        end
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
        bus.i_start    = 1'b0;
        chk("feed_consumed", 64'(i), 64'(s.size()));
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!bus.o_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_reached", 64'(bus.o_done), 64'd1);
    endtask

    task automatic run_load(input string tag, input byte_q_t s, input int mode, input int start_at);
        got_a.delete();
        got_d.delete();
        we_b2b = 0;
        model(s);
        do_start();
        feed(s, mode, start_at);
        wait_done();
        chk({tag, "_nwrites"}, 64'(got_a.size()), 64'(exp_a.size()));
        for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
            chk({tag, "_addr"}, 64'(got_a[k]), 64'(exp_a[k]));
            chk({tag, "_data"}, 64'(got_d[k]), 64'(exp_d[k]));
        end
        chk({tag, "_err"},       64'(bus.o_err),       64'(exp_err));
        chk({tag, "_cpu_rst_n"}, 64'(bus.o_cpu_rst_n), 64'(!exp_err));
        chk({tag, "_busy"},      64'(bus.o_busy),      64'd0);
        chk({tag, "_we_b2b"},    64'(we_b2b),          64'd0);
    endtask

    function automatic byte_q_t with_chk(input byte_q_t s, input logic corrupt);
        byte_q_t r = s;
        logic [7:0] sum = 8'd0;
`ifdef INST_LOADER_CHKSUM_EN
        for (int k = 2; k < s.size(); k++) sum = sum + s[k];
        r.push_back(corrupt ? sum + 8'd1 : sum);
`else
        sum = {7'd0, corrupt};
`endif
        return r;
    endfunction

    byte_q_t base_s;
    byte_q_t s;

    initial begin
        bus.i_start    = 1'b0;
        bus.i_rx_data  = 8'd0;
        bus.i_rx_valid = 1'b0;
        base_s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        base_s = with_chk(base_s, 1'b0);

        // Reset and idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_cpu_rst_n", 64'(bus.o_cpu_rst_n), 64'd0);
        chk("rst_rx_ready",  64'(bus.o_rx_ready),  64'd0);
        chk("rst_we",        64'(bus.o_we),        64'd0);
        chk("rst_done",      64'(bus.o_done),      64'd0);
        chk("rst_busy",      64'(bus.o_busy),      64'd0);
        chk("rst_waddr",     64'(bus.o_waddr),     64'd0);

        // Directed two-word image, then known constants
        run_load("dir", base_s, 0, -1);
        if (got_d.size() == 2) begin
            chk("dir_w0", 64'(got_d[0]), 64'h0010_0513);
            chk("dir_w1", 64'(got_d[1]), 64'h0020_0593);
        end else begin
            chk("dir_count", 64'(got_d.size()), 64'd2);
        end

        // Toggling valid, with a start pulse mid-load that must be ignored
        run_load("tog", base_s, 1, 5);

        // Oversized header
        s = '{8'h01, 8'h04};
        run_load("ovf", s, 0, -1);
        chk("ovf_done", 64'(bus.o_done), 64'd1);
        do_start();
        chk("ovf_restart_err",  64'(bus.o_err),  64'd0);
        chk("ovf_restart_busy", 64'(bus.o_busy), 64'd1);
        chk("ovf_restart_cpu",  64'(bus.o_cpu_rst_n), 64'd0);
        s = with_chk('{8'h00, 8'h00}, 1'b0);
        feed(s, 0, -1);
        wait_done();
        chk("zero_err", 64'(bus.o_err),       64'd0);
        chk("zero_cpu", 64'(bus.o_cpu_rst_n), 64'd1);

`ifdef INST_LOADER_CHKSUM_EN
        s = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
        run_load("chk_bad", s, 0, -1);
        chk("chk_bad_err", 64'(bus.o_err), 64'd1);
        s = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        run_load("chk_good", s, 0, -1);
        chk("chk_good_err", 64'(bus.o_err), 64'd0);
`endif

        // Randomised images with random valid gaps
        for (int t = 0; t < 6; t++) begin
            int n = $urandom_range(1, 5);
            s = '{8'(n), 8'h00};
            for (int k = 0; k < 4 * n; k++) s.push_back(8'($urandom));
            s = with_chk(s, 1'($urandom_range(0, 3) == 0));
            run_load("rnd", s, 2, -1);
        end

        // Reset in the middle of word 0
        got_a.delete();
        do_start();
        s = '{8'h02, 8'h00, 8'h13, 8'h05};
        feed(s, 0, -1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(bus.o_rx_ready),  64'd0);
        chk("mid_rst_we",    64'(bus.o_we),        64'd0);
        chk("mid_rst_busy",  64'(bus.o_busy),      64'd0);
        chk("mid_rst_done",  64'(bus.o_done),      64'd0);
        chk("mid_rst_cpu",   64'(bus.o_cpu_rst_n), 64'd0);
        chk("mid_rst_waddr", 64'(bus.o_waddr),     64'd0);
        chk("mid_rst_wdata", 64'(bus.o_wdata),     64'd0);
        chk("mid_rst_nowr",  64'(got_a.size()),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_load("post_rst", base_s, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
